// File: rtl/cube_raster_seq.sv
// Frame sequencer for the cube raster LED shifter: per-pixel datapath micro-ops,
// one-wire bit waveform timing and the trailing latch period.
module cube_raster_seq #(
  parameter int unsigned BITS_PER_PIX = 24,
  parameter int unsigned T_BIT        = 20,
  parameter int unsigned T0H          = 6,
  parameter int unsigned T1H          = 13,
  parameter int unsigned T_LATCH      = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] num_pix,
  input  logic       pix_avail,
  output logic       busy,
  output logic       done,
  output logic       underrun,
  output logic [2:0] dp_addr,
  output logic       fifo0_load,
  output logic       fifo1_load,
  output logic       fifo0_en_load,
  output logic       clear_add,
  output logic       latch_add,
  output logic       data_en,
  output logic       data_zero,
  output logic       latch_shift,
  output logic       last_bit,
  output logic       one_bit,
  output logic       zero_bit
);

  localparam int unsigned CMAX = (T_LATCH > T_BIT) ? T_LATCH : T_BIT;
  localparam int unsigned CW   = $clog2(CMAX + 1);
  localparam int unsigned BW   = $clog2(BITS_PER_PIX);

  localparam logic [CW-1:0] C_TBIT_M1 = CW'(T_BIT - 1);
  localparam logic [CW-1:0] C_T0H     = CW'(T0H);
  localparam logic [CW-1:0] C_T1H     = CW'(T1H);
  localparam logic [CW-1:0] C_T1H_M1  = CW'(T1H - 1);
  localparam logic [CW-1:0] C_T1H_P4  = CW'(T1H + 4);
  localparam logic [CW-1:0] C_TLATCH  = CW'(T_LATCH);
  localparam logic [CW-1:0] C_ONE     = CW'(1);
  localparam logic [BW-1:0] C_BITLAST = BW'(BITS_PER_PIX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_BITS,
    S_STALL,
    S_LATCH
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;
  logic [BW-1:0] r_bit,   w_bit_nxt;
  logic [2:0]    r_slot,  w_slot_nxt;
  logic          r_go,    w_go_nxt;
  logic          r_ov,    w_ov_nxt;
  logic [9:0]    r_pix,   w_pix_nxt;
  logic [9:0]    r_num,   w_num_nxt;

  logic       w_final, w_more;
  logic       w_slot_act;
  logic [2:0] w_slot_idx;

  logic       w_busy, w_done, w_underrun;
  logic [2:0] w_addr;
  logic       w_en_load, w_clear_add, w_latch_add;
  logic       w_data_en, w_data_zero, w_latch_shift, w_last_bit, w_one_bit, w_zero_bit;

  assign w_final    = (r_bit == C_BITLAST);
  assign w_more     = (r_pix != (r_num - 10'd1));
  assign fifo0_load = 1'b0;
  assign fifo1_load = 1'b0;

  // State/counters, plus output registers: outputs are decoded from the
  // current state and land one cycle later, so every phase is shifted uniformly.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_bit         <= '0;
      r_slot        <= '0;
      r_go          <= 1'b0;
      r_ov          <= 1'b0;
      r_pix         <= '0;
      r_num         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      underrun      <= 1'b0;
      dp_addr       <= '0;
      fifo0_en_load <= 1'b0;
      clear_add     <= 1'b0;
      latch_add     <= 1'b0;
      data_en       <= 1'b0;
      data_zero     <= 1'b0;
      latch_shift   <= 1'b0;
      last_bit      <= 1'b0;
      one_bit       <= 1'b0;
      zero_bit      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_bit         <= w_bit_nxt;
      r_slot        <= w_slot_nxt;
      r_go          <= w_go_nxt;
      r_ov          <= w_ov_nxt;
      r_pix         <= w_pix_nxt;
      r_num         <= w_num_nxt;
      busy          <= w_busy;
      done          <= w_done;
      underrun      <= w_underrun;
      dp_addr       <= w_addr;
      fifo0_en_load <= w_en_load;
      clear_add     <= w_clear_add;
      latch_add     <= w_latch_add;
      data_en       <= w_data_en;
      data_zero     <= w_data_zero;
      latch_shift   <= w_latch_shift;
      last_bit      <= w_last_bit;
      one_bit       <= w_one_bit;
      zero_bit      <= w_zero_bit;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_slot_nxt  = r_slot;
    w_go_nxt    = r_go;
    w_ov_nxt    = r_ov;
    w_pix_nxt   = r_pix;
    w_num_nxt   = r_num;
    case (r_state)
      S_IDLE: begin
        if (start && (num_pix != '0)) begin
          w_state_nxt = S_PREP;
          w_go_nxt    = 1'b0;
          w_slot_nxt  = '0;
          w_num_nxt   = num_pix;
          w_pix_nxt   = '0;
        end
      end
      S_PREP: begin
        if (!r_go) begin
          if (pix_avail) begin
            w_go_nxt   = 1'b1;
            w_slot_nxt = '0;
          end
        end else if (r_slot == 3'd5) begin
          w_state_nxt = S_BITS;
          w_go_nxt    = 1'b0;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
        end else begin
          w_slot_nxt = r_slot + 3'd1;
        end
      end
      S_BITS: begin
        if (r_cnt == C_TBIT_M1) begin
          w_cnt_nxt = '0;
          if (!w_final) begin
            w_bit_nxt = r_bit + BW'(1);
          end else begin
            w_bit_nxt = '0;
            w_ov_nxt  = 1'b0;
            if (!w_more) begin
              w_state_nxt = S_LATCH;
            end else begin
              w_pix_nxt = r_pix + 10'd1;
              if (!r_ov) w_state_nxt = S_STALL;
            end
          end
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
          // Boundary sample: decides between overlapped prep and a stall.
          if (w_final && w_more && (r_cnt == C_T1H_M1)) w_ov_nxt = pix_avail;
        end
      end
      S_STALL: begin
        if (pix_avail) begin
          w_state_nxt = S_PREP;
          w_go_nxt    = 1'b1;
          w_slot_nxt  = '0;
        end
      end
      S_LATCH: begin
        if (r_cnt == C_TLATCH) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy        = 1'b0;
    w_done        = 1'b0;
    w_addr        = '0;
    w_en_load     = 1'b0;
    w_clear_add   = 1'b0;
    w_latch_add   = 1'b0;
    w_data_en     = 1'b0;
    w_data_zero   = 1'b0;
    w_latch_shift = 1'b0;
    w_last_bit    = 1'b0;
    w_one_bit     = 1'b0;
    w_zero_bit    = 1'b0;
    w_slot_act    = 1'b0;
    w_slot_idx    = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (num_pix == '0) w_done = 1'b1;
          else               w_busy = 1'b1;
        end
      end
      S_PREP: begin
        w_busy      = 1'b1;
        w_data_en   = 1'b1;
        w_data_zero = 1'b1;
        w_slot_act  = r_go;
        w_slot_idx  = r_slot;
      end
      S_BITS: begin
        w_busy        = 1'b1;
        w_data_en     = 1'b1;
        w_zero_bit    = (r_cnt < C_T0H);
        w_one_bit     = (r_cnt < C_T1H);
        w_latch_shift = (r_cnt == '0);
        w_last_bit    = w_final;
        if (r_cnt == C_ONE) w_addr = 3'd7;
        w_slot_act    = r_ov && (r_cnt >= C_T1H) && (r_cnt <= C_T1H_P4);
        w_slot_idx    = 3'(r_cnt - C_T1H);
      end
      S_STALL: begin
        w_busy      = 1'b1;
        w_data_en   = 1'b1;
        w_data_zero = 1'b1;
      end
      S_LATCH: begin
        if (r_cnt != C_TLATCH) begin
          w_busy      = 1'b1;
          w_data_en   = 1'b1;
          w_data_zero = 1'b1;
        end else begin
          w_done = 1'b1;
        end
      end
      default: ;
    endcase
    if (w_slot_act) begin
      case (w_slot_idx)
        3'd0: w_addr = 3'd1;
        3'd1: begin w_addr = 3'd2; w_en_load = 1'b1; end
        3'd2: w_addr = 3'd3;
        3'd3: begin w_addr = 3'd4; w_latch_add = 1'b1; end
        3'd4: w_clear_add = 1'b1;
        default: ;
      endcase
    end
    w_underrun = (r_state == S_IDLE && start) ? 1'b0 : (underrun || (r_state == S_STALL));
  end

endmodule

// File: tb/tb_cube_raster_seq.sv
// Directed bench for cube_raster_seq: each frame is logged cycle by cycle after
// start, then specific cycles and per-frame totals are compared to hand values.
module tb_cube_raster_seq;
  logic       clk = 1'b0;
  logic       reset, start, pix_avail;
  logic [9:0] num_pix;
  logic       busy, done, underrun, fifo0_load, fifo1_load, fifo0_en_load;
  logic       clear_add, latch_add, data_en, data_zero, latch_shift, last_bit, one_bit, zero_bit;
  logic [2:0] dp_addr;

  always #5 clk = ~clk;

  cube_raster_seq #(.BITS_PER_PIX(24), .T_BIT(20), .T0H(6), .T1H(13), .T_LATCH(1000)) dut (
    .clk(clk), .reset(reset), .start(start), .num_pix(num_pix), .pix_avail(pix_avail),
    .busy(busy), .done(done), .underrun(underrun), .dp_addr(dp_addr),
    .fifo0_load(fifo0_load), .fifo1_load(fifo1_load), .fifo0_en_load(fifo0_en_load),
    .clear_add(clear_add), .latch_add(latch_add), .data_en(data_en), .data_zero(data_zero),
    .latch_shift(latch_shift), .last_bit(last_bit), .one_bit(one_bit), .zero_bit(zero_bit)
  );

  // {busy,done,underrun,addr[2:0],f0l,f1l,en_load,clear_add,latch_add,den,dz,ls,lb,one,zero}
  logic [16:0] w_all;
  assign w_all = {busy, done, underrun, dp_addr, fifo0_load, fifo1_load, fifo0_en_load,
                  clear_add, latch_add, data_en, data_zero, latch_shift, last_bit, one_bit, zero_bit};

  localparam logic [16:0] B_BUSY = 17'h10000, B_DONE = 17'h08000, B_UND = 17'h04000;
  localparam logic [16:0] A1 = 17'h00800, A2 = 17'h01000, A3 = 17'h01800, A4 = 17'h02000, A7 = 17'h03800;
  localparam logic [16:0] B_ENL = 17'h00100, B_CLR = 17'h00080, B_LAT = 17'h00040;
  localparam logic [16:0] B_DEN = 17'h00020, B_DZ = 17'h00010, B_LS = 17'h00008;
  localparam logic [16:0] B_LB = 17'h00004, B_ONE = 17'h00002, B_ZERO = 17'h00001;
  localparam logic [16:0] PZ = B_BUSY | B_DEN | B_DZ;
  localparam logic [16:0] BD = B_BUSY | B_DEN;
  localparam int F_UND = 14, F_DZ = 4, F_LS = 3, F_LB = 2, F_ONE = 1, F_ZERO = 0;
  localparam int NMAX = 2600;

  logic [16:0] log_v [NMAX];
  int g_n = 0;
  int checks = 0;
  int failures = 0;

  task automatic chkv(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called right after a negedge; log index k is the output state after the k-th posedge.
  task automatic run(input int n, input int ncyc, input int lo, input int hi,
                     input int st_at, input int rst_at);
    num_pix = 10'(n);
    start   = 1'b1;
    g_n     = ncyc;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      log_v[k]  = w_all;
      start     = (k == st_at);
      pix_avail = !(k >= lo && k < hi);
      reset     = (k == rst_at);
    end
    start = 1'b0; reset = 1'b0; pix_avail = 1'b1;
  endtask

  function automatic int cnt_bit(input int f, input int lo, input int hi);
    int c = 0;
    for (int k = lo; k < hi; k++) if (log_v[k][f]) c++;
    return c;
  endfunction

  function automatic int cnt_addr(input int a, input int lo, input int hi);
    int c = 0;
    for (int k = lo; k < hi; k++) if (log_v[k][13:11] == 3'(a)) c++;
    return c;
  endfunction

  function automatic int cnt_nz(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k < hi; k++) if (log_v[k] != '0) c++;
    return c;
  endfunction

  function automatic int first_done();
    for (int k = 0; k < g_n; k++) if (log_v[k][15]) return k;
    return -1;
  endfunction

  logic [16:0] slot_exp [6];
  logic [16:0] ov_exp [8];
  logic [11:0] w_addrs;

  initial begin
    slot_exp = '{PZ | A1, PZ | A2 | B_ENL, PZ | A3, PZ | A4 | B_LAT, PZ | B_CLR, PZ};
    ov_exp   = '{BD | B_LB | A1, BD | B_LB | A2 | B_ENL, BD | B_LB | A3, BD | B_LB | A4 | B_LAT,
                 BD | B_LB | B_CLR, BD | B_LB, BD | B_LB, BD | B_LS | B_ONE | B_ZERO};
    reset = 1'b1; start = 1'b0; num_pix = '0; pix_avail = 1'b1;
    repeat (3) @(negedge clk);
    chkv("reset_outputs", w_all, '0);
    reset = 1'b0;
    @(negedge clk);
    chkv("idle_after_reset", w_all, '0);

    // Empty frame
    run(0, 4, -1, -1, -1, -1);
    chkv("np0_done", log_v[0], B_DONE);
    chkv("np0_after", log_v[1], '0);
    chki("np0_quiet", cnt_nz(1, 4), 0);

    // Single pixel
    run(1, 1500, -1, -1, -1, -1);
    chkv("n1_k0", log_v[0], B_BUSY);
    chkv("n1_wait_k1", log_v[1], PZ);
    for (int i = 0; i < 6; i++) chkv($sformatf("n1_slot%0d", i), log_v[2 + i], slot_exp[i]);
    chkv("n1_c0", log_v[8], BD | B_LS | B_ONE | B_ZERO);
    chkv("n1_c1", log_v[9], BD | A7 | B_ONE | B_ZERO);
    chkv("n1_c6", log_v[14], BD | B_ONE);
    chkv("n1_c13", log_v[21], BD);
    chki("n1_ls_count", cnt_bit(F_LS, 0, 1500), 24);
    chki("n1_a7_count", cnt_addr(7, 0, 1500), 24);
    chki("n1_zero_count", cnt_bit(F_ZERO, 0, 1500), 144);
    chki("n1_one_count", cnt_bit(F_ONE, 0, 1500), 312);
    chki("n1_lb_count", cnt_bit(F_LB, 468, 488), 20);
    chki("n1_lb_total", cnt_bit(F_LB, 0, 1500), 20);
    chkv("n1_lb_first", log_v[468], BD | B_LB | B_LS | B_ONE | B_ZERO);
    chkv("n1_lb_last", log_v[487], BD | B_LB);
    chkv("n1_latch_first", log_v[488], PZ);
    chki("n1_latch_dz", cnt_bit(F_DZ, 488, 1488), 1000);
    chki("n1_done_at", first_done(), 1488);
    chkv("n1_done_vec", log_v[1488], B_DONE);
    chkv("n1_after", log_v[1489], '0);

    // Seamless three-pixel stream
    run(3, 2460, -1, -1, -1, -1);
    chki("n3_ls_count", cnt_bit(F_LS, 0, 2460), 72);
    chki("n3_a7_count", cnt_addr(7, 0, 2460), 72);
    chki("n3_underrun", cnt_bit(F_UND, 0, 2460), 0);
    chki("n3_no_gap", cnt_bit(F_DZ, 8, 1448), 0);
    chki("n3_done_at", first_done(), 2448);
    chkv("n3_sample_c12", log_v[480], BD | B_LB | B_ONE);
    for (int i = 0; i < 8; i++) chkv($sformatf("n3_ovl%0d", i), log_v[481 + i], ov_exp[i]);
    w_addrs = {log_v[961][13:11], log_v[962][13:11], log_v[963][13:11], log_v[964][13:11]};
    chkv("n3_ovl_px1_addr", {5'd0, w_addrs}, 17'o1234);

    // Underrun at the pixel-0 boundary
    run(2, 2020, 470, 520, -1, -1);
    chkv("st_c12", log_v[480], BD | B_LB | B_ONE);
    chkv("st_no_ovl", log_v[481], BD | B_LB);
    chkv("st_lastcyc", log_v[487], BD | B_LB);
    chkv("st_enter", log_v[488], PZ | B_UND);
    chkv("st_hold", log_v[521], PZ | B_UND);
    chkv("st_prep0", log_v[522], PZ | B_UND | A1);
    chkv("st_prep1", log_v[523], PZ | B_UND | A2 | B_ENL);
    chkv("st_px1_c0", log_v[528], BD | B_UND | B_LS | B_ONE | B_ZERO);
    chki("st_ls_count", cnt_bit(F_LS, 0, 2020), 48);
    chki("st_done_at", first_done(), 2008);
    chkv("st_done_vec", log_v[2008], B_DONE | B_UND);

    // Start pulse mid-frame is ignored; start also clears underrun
    run(1, 1500, -1, -1, 200, -1);
    chkv("ms_k0", log_v[0], B_BUSY);
    chki("ms_done_at", first_done(), 1488);
    chki("ms_ls_count", cnt_bit(F_LS, 0, 1500), 24);

    // Reset during bit 10 of pixel 0, then a clean frame
    run(1, 260, -1, -1, -1, 210);
    chkv("rs_bit10", log_v[210], BD | B_ONE | B_ZERO);
    chkv("rs_cleared", log_v[211], '0);
    chki("rs_quiet", cnt_nz(211, 260), 0);
    run(1, 1500, -1, -1, -1, -1);
    chkv("rs_slot0", log_v[2], PZ | A1);
    chki("rs_done_at", first_done(), 1488);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
